// File: rtl/baccarat_sequencer_pkg.sv
// Shared definitions for the baccarat hand sequencer: state encoding, scoring
// thresholds and the card rank-to-value mapping.
package baccarat_sequencer_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_P1     = 4'd1;
  localparam state_t S_D1     = 4'd2;
  localparam state_t S_P2     = 4'd3;
  localparam state_t S_D2     = 4'd4;
  localparam state_t S_EVAL_P = 4'd5;
  localparam state_t S_P3     = 4'd6;
  localparam state_t S_EVAL_D = 4'd7;
  localparam state_t S_D3     = 4'd8;
  localparam state_t S_SCORE  = 4'd9;
  localparam state_t S_DONE   = 4'd10;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
  localparam logic [3:0] DEALER_STAND     = 4'd7;

  // Ace..9 count face value; 10, J, Q, K, "no card" and illegal codes count 0.
  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    return ((rank >= 4'd1) && (rank <= 4'd9)) ? rank : 4'd0;
  endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card tableau: decides whether the dealer draws given its total
// and the value of the player's third card.
module dealer_draw_rule
  import baccarat_sequencer_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] t,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    if (dscore < DEALER_STAND) begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (t != 4'd8);
        4'd4:             draw = (t >= 4'd2) && (t <= 4'd7);
        4'd5:             draw = (t >= 4'd4) && (t <= 4'd7);
        4'd6:             draw = (t >= 4'd6) && (t <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_sequencer.sv
// Control FSM for one baccarat hand: deals four cards, applies the third-card
// rules, then latches the win lights and parks in S_DONE until reset.
module baccarat_sequencer
  import baccarat_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3_in,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       hand_done
);

  state_t     state_q, state_d;
  logic       player_win_q, dealer_win_q;
  logic [3:0] pcard3_value;
  logic       dealer_draw;
  logic       p_natural, d_natural;

  assign pcard3_value = rank_value(pcard3_in);

  dealer_draw_rule u_dealer_draw_rule (
    .dscore (dscore),
    .t      (pcard3_value),
    .draw   (dealer_draw)
  );

  // Out-of-range totals (10..15) must not count as naturals.
  assign p_natural = (pscore >= NATURAL_MIN) && (pscore <= 4'd9);
  assign d_natural = (dscore >= NATURAL_MIN) && (dscore <= 4'd9);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_P1;
      S_P1:     state_d = S_D1;
      S_D1:     state_d = S_P2;
      S_P2:     state_d = S_D2;
      S_D2:     state_d = S_EVAL_P;
      S_EVAL_P: begin
        if (p_natural || d_natural) begin
          state_d = S_SCORE;
        end else if (pscore < PLAYER_STAND_MIN) begin
          state_d = S_P3;
        end else if (dscore <= 4'd5) begin
          state_d = S_D3;
        end else begin
          state_d = S_SCORE;
        end
      end
      S_P3:     state_d = S_EVAL_D;
      S_EVAL_D: state_d = dealer_draw ? S_D3 : S_SCORE;
      S_D3:     state_d = S_SCORE;
      S_SCORE:  state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      player_win_q <= 1'b0;
      dealer_win_q <= 1'b0;
    end else if (state_q == S_SCORE) begin
      player_win_q <= (pscore >= dscore);
      dealer_win_q <= (dscore >= pscore);
    end
  end

  assign load_pcard1      = (state_q == S_P1);
  assign load_dcard1      = (state_q == S_D1);
  assign load_pcard2      = (state_q == S_P2);
  assign load_dcard2      = (state_q == S_D2);
  assign load_pcard3      = (state_q == S_P3);
  assign load_dcard3      = (state_q == S_D3);
  assign hand_done        = (state_q == S_DONE);
  assign player_win_light = player_win_q;
  assign dealer_win_light = dealer_win_q;

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Self-checking bench for baccarat_sequencer: directed and random hands against
// a rule-level model, mid-hand reset, and a full dealer tableau sweep.
module tb_baccarat_sequencer;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3_in = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, hand_done;
  logic [8:0] obs;

  logic [3:0] sw_d = 4'd0;
  logic [3:0] sw_t = 4'd0;
  logic       sw_draw;

  int checks = 0;
  int errors = 0;

  localparam int PH_P1 = 1, PH_D1 = 2, PH_P2 = 3, PH_D2 = 4, PH_EVP = 5, PH_P3 = 6;
  localparam int PH_EVD = 7, PH_D3 = 8, PH_SCORE = 9, PH_DONE = 10;

  always #5 clock = ~clock;

  baccarat_sequencer dut (
    .clock            (clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3_in        (pcard3_in),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .hand_done        (hand_done)
  );

  dealer_draw_rule u_sweep (
    .dscore (sw_d),
    .t      (sw_t),
    .draw   (sw_draw)
  );

  assign obs = {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
                player_win_light, dealer_win_light, hand_done};

  function automatic int tval(input int rank);
    return (rank >= 1 && rank <= 9) ? rank : 0;
  endfunction

  // Tableau: totals 4..6 draw on t from 2*(d-3) up to 7; 3 draws on all but 8.
  function automatic bit dealer_draws(input int d, input int t);
    if (d <= 2) return 1'b1;
    if (d >= 7) return 1'b0;
    if (d == 3) return t != 8;
    return (t >= 2 * (d - 3)) && (t <= 7);
  endfunction

  function automatic logic [8:0] expect_vec(input int ph, input int pf, input int df);
    logic [8:0] v;
    v = 9'd0;
    case (ph)
      PH_P1: v[8] = 1'b1;
      PH_P2: v[7] = 1'b1;
      PH_P3: v[6] = 1'b1;
      PH_D1: v[5] = 1'b1;
      PH_D2: v[4] = 1'b1;
      PH_D3: v[3] = 1'b1;
      PH_DONE: begin
        v[2] = (pf >= df);
        v[1] = (df >= pf);
        v[0] = 1'b1;
      end
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  task automatic check_vec(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (p1 p2 p3 d1 d2 d3 pw dw done)", tag, got, want);
    end
  endtask

  task automatic start_hand(input string tag, input int pe, input int de, input int c3);
    @(posedge clock);
    #1;
    resetb    = 1'b0;
    pscore    = 4'(pe);
    dscore    = 4'(de);
    pcard3_in = 4'(c3);
    #1;
    check_vec({tag, "/reset"}, obs, 9'd0);
    @(negedge clock);
    resetb = 1'b1;
  endtask

  // pe/de/c3 drive the evaluation states; pf/df are the final totals at scoring.
  task automatic play_hand(input string tag, input int pe, input int de, input int c3,
                           input int pf, input int df);
    int  path[$];
    int  done_at;
    path.push_back(PH_P1);
    path.push_back(PH_D1);
    path.push_back(PH_P2);
    path.push_back(PH_D2);
    path.push_back(PH_EVP);
    if (!(pe == 8 || pe == 9 || de == 8 || de == 9)) begin
      if (pe <= 5) begin
        path.push_back(PH_P3);
        path.push_back(PH_EVD);
        if (dealer_draws(de, tval(c3))) path.push_back(PH_D3);
      end else if (de <= 5) begin
        path.push_back(PH_D3);
      end
    end
    path.push_back(PH_SCORE);
    done_at = path.size() + 1;
    for (int k = 0; k < 3; k++) path.push_back(PH_DONE);
    start_hand(tag, pe, de, c3);
    for (int i = 0; i < path.size(); i++) begin
      @(posedge clock);
      #1;
      check_vec($sformatf("%s/cyc%0d", tag, i + 1), obs, expect_vec(path[i], pf, df));
      if (path[i] == PH_SCORE) begin
        pscore = 4'(pf);
        dscore = 4'(df);
      end
    end
    if (done_at != 7 && done_at != 8 && done_at != 9 && done_at != 10) begin
      errors++;
      $error("FAIL %s/latency: observed %0d expected 7..10", tag, done_at);
    end
  endtask

  initial begin
    int pe, de, c3, pf, df;

    // Directed hands
    play_hand("natural_p8_d3", 8, 3, 0, 8, 3);
    play_hand("p4_d3_t8_stand", 4, 3, 8, 9, 3);
    play_hand("p2_d5_q_stand", 2, 5, 12, 7, 7);
    play_hand("p2_d5_t5_draw", 2, 5, 5, 7, 7);
    play_hand("p6_d5_dealer_only", 6, 5, 0, 6, 5);
    play_hand("p7_d6_both_stand", 7, 6, 0, 7, 6);
    play_hand("p12_d3_oor", 12, 3, 0, 4, 9);
    play_hand("p3_d11_oor", 3, 11, 1, 3, 2);
    play_hand("d9_natural", 1, 9, 3, 1, 9);

    // Mid-hand reset while loading the player's third card
    start_hand("midreset", 3, 4, 2);
    for (int i = 0; i < 6; i++) @(posedge clock);
    #1;
    check_vec("midreset/in_p3", obs, expect_vec(PH_P3, 0, 0));
    #2;
    resetb = 1'b0;
    #1;
    check_vec("midreset/async_clear", obs, 9'd0);
    @(posedge clock);
    #1;
    check_vec("midreset/held", obs, 9'd0);
    @(negedge clock);
    resetb = 1'b1;
    @(posedge clock);
    #1;
    check_vec("midreset/restart_p1", obs, expect_vec(PH_P1, 0, 0));

    // Random hands
    for (int n = 0; n < 40; n++) begin
      pe = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      de = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      c3 = $urandom_range(0, 15);
      pf = $urandom_range(0, 9);
      df = $urandom_range(0, 9);
      play_hand($sformatf("rand%0d_p%0d_d%0d_c%0d", n, pe, de, c3), pe, de, c3, pf, df);
    end

    // Dealer tableau sweep, including out-of-range totals
    for (int d = 0; d < 16; d++) begin
      for (int c = 0; c < 14; c++) begin
        sw_d = 4'(d);
        sw_t = 4'(tval(c));
        #1;
        checks++;
        assert (sw_draw === dealer_draws(d, tval(c))) else begin
          errors++;
          $error("FAIL rule_d%0d_c%0d: observed %b expected %b", d, c, sw_draw,
                 dealer_draws(d, tval(c)));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
